// File: rtl/sc_bitstream_decoder.sv
// Stochastic-to-binary decoder: counts 1s over a 2^WIN_LOG2-sample window and
// presents the count on a valid/ready output. Optional sticky overrun flag: SC_DECODER_OVERRUN_EN.
module sc_bitstream_decoder #(
  parameter int unsigned WIN_LOG2 = 8,
  parameter int unsigned OUT_W    = WIN_LOG2 + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             busy,
  output logic [OUT_W-1:0] count_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t              state, next_state;
  logic [OUT_W-1:0]    acc;
  logic [WIN_LOG2-1:0] sample_cnt;
  logic                start_accept;
  logic                win_end;
  logic                handshake;
  logic [OUT_W-1:0]    bit_ext;

  assign bit_ext = OUT_W'(bit_in);

  always_comb begin
    next_state   = state;
    busy         = 1'b0;
    out_valid    = 1'b0;
    handshake    = 1'b0;
    start_accept = 1'b0;
    win_end      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_accept = 1'b1;
          next_state   = ACCUM;
        end
      end
      ACCUM: begin
        busy = 1'b1;
        if (bit_valid && (sample_cnt == '1)) begin
          win_end    = 1'b1;
          next_state = HOLD;
        end
      end
      HOLD: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          handshake = 1'b1;
          if (start) begin
            start_accept = 1'b1;
            next_state   = ACCUM;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // sample_cnt wraps to 0 on the final sample, so a back-to-back window starts clean either way
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      sample_cnt <= '0;
      count_out  <= '0;
    end else begin
      if (start_accept) begin
        acc        <= '0;
        sample_cnt <= '0;
      end else if ((state == ACCUM) && bit_valid) begin
        acc        <= acc + bit_ext;
        sample_cnt <= sample_cnt + 1'b1;
      end
      if (win_end) count_out <= acc + bit_ext;
    end
  end

`ifdef SC_DECODER_OVERRUN_EN
  logic overrun_q;

  // An accepted start clears the flag even if a dropped sample arrives in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             overrun_q <= 1'b0;
    else if (start_accept)                  overrun_q <= 1'b0;
    else if ((state == HOLD) && bit_valid)  overrun_q <= 1'b1;
  end

  assign overrun = overrun_q;
`else
  logic unused_hs;
  assign unused_hs = handshake;
  assign overrun   = 1'b0;
`endif

endmodule

// File: tb/tb_sc_bitstream_decoder.sv
// Directed self-checking bench for sc_bitstream_decoder at WIN_LOG2=4 (window of 16).
module tb_sc_bitstream_decoder;

  localparam int unsigned WL = 4;
  localparam int unsigned OW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          bit_in = 1'b0;
  logic          bit_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          busy;
  logic [OW-1:0] count_out;
  logic          out_valid;
  logic          overrun;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef SC_DECODER_OVERRUN_EN
  localparam logic OVR_ON = 1'b1;
`else
  localparam logic OVR_ON = 1'b0;
`endif

  sc_bitstream_decoder #(.WIN_LOG2(WL), .OUT_W(OW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .busy      (busy),
    .count_out (count_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (count_out !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count_out); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun); end
    rst_n = 1'b1;
    tick();
    // bit_valid in IDLE must be ignored
    bit_valid = 1'b1; bit_in = 1'b1;
    tick(); tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_ignore_busy got %b want 0", busy); end
    bit_valid = 1'b0; bit_in = 1'b0;
  endtask

  task automatic test_all_ones;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ones_busy_start got %b want 1", busy); end
    bit_valid = 1'b1; bit_in = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i < 15) begin
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
          n_fail++; $display("FAIL ones_early sample %0d out_valid=%b busy=%b want 0/1", i, out_valid, busy);
        end
      end
    end
    bit_valid = 1'b0; bit_in = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ones_valid got %b want 1", out_valid); end
    n_checks++; if (count_out !== 5'b10000) begin n_fail++; $display("FAIL ones_count got %0d want 16", count_out); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ones_busy_hold got %b want 1", busy); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL ones_release out_valid=%b busy=%b want 0/0", out_valid, busy); end
    n_checks++; if (count_out !== 5'd16) begin n_fail++; $display("FAIL ones_retain got %0d want 16", count_out); end
  endtask

  task automatic test_gaps;
    int v;
    int c;
    v = 0; c = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (v < 16 && c < 100) begin
      bit_valid = (c % 3) != 2;
      bit_in    = bit_valid ? ((v % 2) == 0) : 1'b1;
      tick();
      if (bit_valid) v++;
      c++;
      if (v < 16) begin
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL gaps_early v=%0d got %b want 0", v, out_valid); end
      end
    end
    bit_valid = 1'b0; bit_in = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL gaps_valid got %b want 1 (cycles %0d)", out_valid, c); end
    n_checks++; if (count_out !== 5'd8) begin n_fail++; $display("FAIL gaps_count got %0d want 8", count_out); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    start = 1'b1;
    tick();
    start = 1'b0;
    bit_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bit_in = (i < 5);
      tick();
    end
    bit_valid = 1'b0; bit_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || count_out !== 5'd5) begin
        n_fail++; $display("FAIL bp_stable cycle %0d out_valid=%b count=%0d want 1/5", i, out_valid, count_out);
      end
    end
    out_ready = 1'b1; start = 1'b1;
    tick();
    out_ready = 1'b0; start = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart out_valid=%b busy=%b want 0/1", out_valid, busy); end
    n_checks++; if (count_out !== 5'd5) begin n_fail++; $display("FAIL b2b_retain got %0d want 5", count_out); end
    bit_valid = 1'b1; bit_in = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    bit_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got %b want 1", out_valid); end
    n_checks++; if (count_out !== 5'd0) begin n_fail++; $display("FAIL b2b_count got %0d want 0", count_out); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_overrun;
    start = 1'b1;
    tick();
    start = 1'b0;
    bit_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bit_in = ((i % 4) == 0);
      tick();
    end
    // dropped samples while holding
    bit_in = 1'b1;
    tick(); tick();
    bit_valid = 1'b0;
    n_checks++; if (overrun !== OVR_ON) begin n_fail++; $display("FAIL ovr_set got %b want %b", overrun, OVR_ON); end
    n_checks++; if (count_out !== 5'd4 || out_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_hold count=%0d valid=%b want 4/1", count_out, out_valid); end
    // handshake+start with a dropped sample in the same cycle: clear wins
    out_ready = 1'b1; start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    out_ready = 1'b0; start = 1'b0;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear_b2b got %b want 0", overrun); end
    for (int i = 0; i < 16; i++) begin
      bit_in = (i < 3);
      tick();
    end
    bit_valid = 1'b0; bit_in = 1'b0;
    n_checks++; if (count_out !== 5'd3 || out_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_next_count count=%0d valid=%b want 3/1", count_out, out_valid); end
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++; if (overrun !== OVR_ON || busy !== 1'b0) begin n_fail++; $display("FAIL ovr_sticky overrun=%b busy=%b want %b/0", overrun, busy, OVR_ON); end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear_idle got %b want 0", overrun); end
    // abandon this window via the mid-window reset test
  endtask

  task automatic test_reset_mid;
    bit_valid = 1'b1; bit_in = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || count_out !== 5'd0 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL midreset busy=%b valid=%b count=%0d overrun=%b want 0/0/0/0", busy, out_valid, count_out, overrun);
    end
    bit_valid = 1'b0; bit_in = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    bit_valid = 1'b1; bit_in = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    bit_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || count_out !== 5'd16) begin n_fail++; $display("FAIL midreset_count valid=%b count=%0d want 1/16", out_valid, count_out); end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_gaps();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
